// File: rtl/mult_seq_pkg.sv
// Shared types and constants for the digit-serial Wallace multiplier sequencer.
package mult_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DIGIT_W  = 4;  // operand digit fed to the core
  localparam int CORE_P_W = 8;  // core product width (2*DIGIT_W)

endpackage

// File: rtl/wallace_tree_multiplier_4bit.sv
// Combinational 4x4 unsigned multiplier: four partial-product rows reduced
// by two carry-save (3:2) layers, then one carry-propagate add.
module wallace_tree_multiplier_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [7:0] p
);

  logic [3:0][7:0] pp;
  logic [7:0]      s1, c1, s2, c2;

  // Partial-product rows, reduced 4 -> 3 -> 2 rows. Carries dropped off the top
  // are harmless because the true product always fits in 8 bits.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      pp[r] = 8'(a & {4{b[r]}}) << r;
    end
    s1 = pp[0] ^ pp[1] ^ pp[2];
    c1 = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    s2 = s1 ^ c1 ^ pp[3];
    c2 = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;
    p  = s2 + c2;
  end

endmodule

// File: rtl/wallace_mul_sequencer.sv
// Multi-cycle WIDTH x WIDTH unsigned multiplier: walks every 4-bit digit pair
// of the captured operands through one shared 4x4 core and accumulates the
// shifted digit products. Valid/ready on both sides.
module wallace_mul_sequencer
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic               busy
);

  localparam int NDIG  = WIDTH / DIGIT_W;
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int ACC_W = 2 * WIDTH;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NDIG - 1);

  if (WIDTH < DIGIT_W || (WIDTH % DIGIT_W) != 0) begin : g_bad_width
    $error("wallace_mul_sequencer: WIDTH must be a multiple of 4 and >= 4");
  end

  state_e                state, state_nxt;
  logic [IDX_W-1:0]      i, j;
  logic [WIDTH-1:0]      a_q, b_q;
  logic [ACC_W-1:0]      acc, pp_shift;
  logic [DIGIT_W-1:0]    core_a, core_b;
  logic [CORE_P_W-1:0]   core_p;
  logic                  last_pair;

  assign core_a      = a_q[DIGIT_W*i +: DIGIT_W];
  assign core_b      = b_q[DIGIT_W*j +: DIGIT_W];
  assign last_pair   = (i == LAST) && (j == LAST);
  assign out_product = acc;

  wallace_tree_multiplier_4bit u_core (
    .a (core_a),
    .b (core_b),
    .p (core_p)
  );

  // Zero-extend the digit product and align it to digit position i+j.
  always_comb begin
    pp_shift = '0;
    pp_shift[CORE_P_W-1:0] = core_p;
    pp_shift = pp_shift << (DIGIT_W * (int'(i) + int'(j)));
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = MUL;
      end
      MUL: begin
        busy = 1'b1;
        if (last_pair) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture, digit-pair counters (j inner, i outer) and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      acc <= '0;
      i   <= '0;
      j   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= in_a;
            b_q <= in_b;
            acc <= '0;
            i   <= '0;
            j   <= '0;
          end
        end
        MUL: begin
          acc <= acc + pp_shift;
          if (last_pair) begin
            i <= '0;
            j <= '0;
          end else if (j == LAST) begin
            j <= '0;
            i <= i + IDX_W'(1);
          end else begin
            j <= j + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_wallace_mul_sequencer.sv
// Bench for wallace_mul_sequencer at WIDTH = 8, 16 and 4 side by side.
// Reference: an outstanding-op model (product = a*b, valid NPAIR cycles after accept).
module tb_wallace_mul_sequencer;

  localparam int NI = 3;  // instance 0: W8, 1: W16, 2: W4

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv   [NI];
  logic        ordy [NI];
  logic [15:0] ina  [NI];
  logic [15:0] inb  [NI];
  logic        irdy_w [NI];
  logic        ov_w   [NI];
  logic        busy_w [NI];
  logic [31:0] prod_w [NI];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  function automatic int wof(input int k);
    case (k)
      0:       return 8;
      1:       return 16;
      default: return 4;
    endcase
  endfunction

  function automatic int npair(input int k);
    int nd;
    nd = wof(k) / 4;
    return nd * nd;
  endfunction

  function automatic logic [31:0] msk(input int k);
    return (32'h1 << wof(k)) - 32'h1;
  endfunction

  function automatic logic [15:0] rnd();
    case ($urandom % 8)
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  for (genvar g = 0; g < NI; g++) begin : gi
    localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : 4;
    logic [2*W-1:0] prod;
    logic           irdy, ov, bsy;

    wallace_mul_sequencer #(.WIDTH(W)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (iv[g]),
      .in_ready    (irdy),
      .in_a        (ina[g][W-1:0]),
      .in_b        (inb[g][W-1:0]),
      .out_valid   (ov),
      .out_ready   (ordy[g]),
      .out_product (prod),
      .busy        (bsy)
    );

    assign irdy_w[g] = irdy;
    assign ov_w[g]   = ov;
    assign busy_w[g] = bsy;
    assign prod_w[g] = 32'(prod);
  end

  task automatic chk(input string nm, input int k, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s[%0d] @%0t: got 0x%0h, expected 0x%0h", nm, k, $time, got, want);
    end
  endtask

  // Reference model: one op outstanding per instance, result a*b, valid once
  // NPAIR cycles have passed since the accept edge, retired on out_ready.
  logic        pend [NI];
  int          age  [NI];
  logic [31:0] expv [NI];
  int          done [NI] = '{0, 0, 0};

  always @(posedge clk or negedge rst_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        pend[k] <= 1'b0;
        age[k]  <= 0;
      end else if (!pend[k]) begin
        if (iv[k]) begin
          pend[k] <= 1'b1;
          age[k]  <= 0;
          expv[k] <= ((32'(ina[k])) & msk(k)) * ((32'(inb[k])) & msk(k));
        end
      end else if (age[k] < npair(k)) begin
        age[k] <= age[k] + 1;
      end else if (ordy[k]) begin
        pend[k] <= 1'b0;
        done[k] <= done[k] + 1;
      end
    end
  end

  // Compare every instance against the model on each falling edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < NI; k++) begin
        logic vexp;
        vexp = pend[k] && (age[k] == npair(k));
        chk("in_ready", k, 32'(irdy_w[k]), 32'(!pend[k]));
        chk("busy",     k, 32'(busy_w[k]), 32'(pend[k]));
        chk("out_valid", k, 32'(ov_w[k]),  32'(vexp));
        if (vexp) chk("product", k, prod_w[k], expv[k]);
      end
    end
  end

  // One directed op; caller is just past a rising edge with the instance idle.
  task automatic run_op(input int k, input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] lit, input int lat, input bit scramble);
    int n;
    ina[k] = a; inb[k] = b; iv[k] = 1'b1; ordy[k] = 1'b1;
    n = 0;
    while (!irdy_w[k] && n < 100) begin @(posedge clk); #1; n++; end
    chk("accept_wait", k, 32'(irdy_w[k]), 32'd1);
    @(posedge clk); #1;
    iv[k] = 1'b0;
    n = 0;
    while (!ov_w[k] && n < 300) begin
      if (scramble) begin ina[k] = 16'($urandom); inb[k] = 16'($urandom); end
      @(posedge clk); #1;
      n++;
    end
    chk("latency", k, 32'(n), 32'(lat));
    chk("product_lit", k, prod_w[k], lit);
    @(posedge clk); #1;
    chk("ready_after", k, 32'(irdy_w[k]), 32'd1);
    chk("valid_after", k, 32'(ov_w[k]), 32'd0);
  endtask

  initial begin
    int n, cyc, b0, b1, b2;
    for (int k = 0; k < NI; k++) begin
      iv[k] = 1'b0; ordy[k] = 1'b0; ina[k] = '0; inb[k] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("rst_in_ready",  k, 32'(irdy_w[k]), 32'd1);
      chk("rst_out_valid", k, 32'(ov_w[k]),   32'd0);
      chk("rst_busy",      k, 32'(busy_w[k]), 32'd0);
      chk("rst_product",   k, prod_w[k],      32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic products, including extremes.
    run_op(0, 16'h12, 16'h34, 32'h03A8, 4, 1'b0);
    run_op(0, 16'hFF, 16'hFF, 32'hFE01, 4, 1'b0);
    run_op(0, 16'h00, 16'hA5, 32'h0000, 4, 1'b0);
    run_op(0, 16'h80, 16'h02, 32'h0100, 4, 1'b0);

    // Consumer stalls for 5 cycles; product must hold and no accept may happen.
    ina[0] = 16'hAB; inb[0] = 16'hCD; iv[0] = 1'b1; ordy[0] = 1'b0;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    n = 0;
    while (!ov_w[0] && n < 300) begin @(posedge clk); #1; n++; end
    chk("stall_latency", 0, 32'(n), 32'd4);
    repeat (5) begin
      chk("stall_product", 0, prod_w[0], 32'h88EF);
      chk("stall_valid",   0, 32'(ov_w[0]),   32'd1);
      chk("stall_ready",   0, 32'(irdy_w[0]), 32'd0);
      @(posedge clk); #1;
    end
    ordy[0] = 1'b1; iv[0] = 1'b1; ina[0] = 16'h03; inb[0] = 16'h05;
    @(posedge clk); #1;
    chk("release_ready", 0, 32'(irdy_w[0]), 32'd1);
    chk("release_valid", 0, 32'(ov_w[0]),   32'd0);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    chk("next_accept_busy", 0, 32'(busy_w[0]), 32'd1);
    n = 0;
    while (!ov_w[0] && n < 300) begin @(posedge clk); #1; n++; end
    chk("next_product", 0, prod_w[0], 32'h000F);
    @(posedge clk); #1;

    // Operands change every cycle after accept; captured values must win.
    run_op(0, 16'h5A, 16'hC3, 32'h448E, 4, 1'b1);

    // Reset in the 2nd MUL cycle discards the op immediately.
    ina[0] = 16'h77; inb[0] = 16'h99; iv[0] = 1'b1; ordy[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 0, 32'(ov_w[0]),   32'd0);
    chk("midrst_busy",      0, 32'(busy_w[0]), 32'd0);
    chk("midrst_in_ready",  0, 32'(irdy_w[0]), 32'd1);
    chk("midrst_product",   0, prod_w[0],      32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_op(0, 16'h0F, 16'h0F, 32'h00E1, 4, 1'b0);

    // Other widths: single-digit and four-digit operands.
    run_op(2, 16'hF, 16'hF, 32'hE1, 1, 1'b0);
    run_op(1, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16, 1'b0);

    // Random back-to-back traffic on all instances, checked by the model.
    b0 = done[0]; b1 = done[1]; b2 = done[2];
    cyc = 0;
    while ((done[0] - b0 < 1000 || done[1] - b1 < 1000 || done[2] - b2 < 200) && cyc < 60000) begin
      for (int k = 0; k < NI; k++) begin
        iv[k]   = ($urandom % 8) != 0;
        ordy[k] = ($urandom % 4) != 0;
        ina[k]  = rnd();
        inb[k]  = rnd();
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk("random_budget", 0, 32'(cyc < 60000), 32'd1);

    for (int k = 0; k < NI; k++) begin iv[k] = 1'b0; ordy[k] = 1'b1; end
    repeat (20) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
